fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 20 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read port and decode-side valid/ready handshake
interface fetch_stage_if #(
    parameter int IMEM_AW = 8
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [31:0]        out_pc_plus4;
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc_plus4,
        input  imem_rdata, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus4,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, 1-cycle imem issue, 2-entry fetch queue, branch-redirect flush.
// Define FETCH_PERF_EN to add the fetch_count/flush_count performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count,
`endif
    fetch_stage_if.master bus
);
    logic [31:0] pc;
    logic [31:0] inflight_addr;
    logic        inflight;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc4 [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [31:0] last_instr;
    logic [31:0] last_pc4;
    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  occ;

    // occ is the queue occupancy after this cycle's pop, counting the slot reserved by inflight
    always_comb begin
        pop   = bus.out_valid && bus.out_ready;
        push  = inflight && !redirect;
        occ   = count + {1'b0, inflight} - {1'b0, pop};
        issue = !rst && !redirect && occ < 2'd2;
    end

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = pc[IMEM_AW+1:2];
    assign bus.out_valid    = count != 2'd0;
    assign bus.out_instr    = bus.out_valid ? q_instr[head] : last_instr;
    assign bus.out_pc_plus4 = bus.out_valid ? q_pc4[head] : last_pc4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC & 32'hFFFF_FFFC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
            count         <= 2'd0;
            last_instr    <= '0;
            last_pc4      <= '0;
        end else begin
            pc            <= redirect ? (redirect_pc & 32'hFFFF_FFFC) : issue ? pc + 32'd4 : pc;
            inflight      <= issue;
            inflight_addr <= issue ? pc : inflight_addr;
            head          <= redirect ? 1'b0 : head ^ pop;
            tail          <= redirect ? 1'b0 : tail ^ push;
            count         <= redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            last_instr    <= bus.out_instr;
            last_pc4      <= bus.out_pc_plus4;
        end
    end

    // queue payload needs no reset: it is only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= bus.imem_rdata;
            q_pc4[tail]   <= inflight_addr + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            fetch_count <= fetch_count + {31'd0, pop && !redirect};
            flush_count <= flush_count + {15'd0, redirect};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a program-path model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem [256];
    logic [31:0] exp_pc = '0;
    int          checks = 0;
    int          errors = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] fetch_count_w;
    logic [15:0] flush_count;
    logic [15:0] flush_count_w;
`endif

    fetch_stage_if #(.IMEM_AW(8)) bus ();
    fetch_stage_if #(.IMEM_AW(8)) bus_w ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count),
        .flush_count(flush_count),
`endif
        .bus(bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(8)) dut_w (
        .clk(clk),
        .rst(rst),
        .redirect(1'b0),
        .redirect_pc(32'h0),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count_w),
        .flush_count(flush_count_w),
`endif
        .bus(bus_w)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory: data valid the cycle after the request
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
        if (bus_w.imem_req) bus_w.imem_rdata <= mem[bus_w.imem_addr];
    end

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return 32'h1000_0000 + {24'd0, p[9:2]};
    endfunction

    task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        bus.out_ready = rdy;
        redirect = redir;
        redirect_pc = rpc;
        #1;
    endtask

    // leaves the bench inside C0, the first cycle with rst low
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        bus.out_ready = rdy;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pc = '0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_req: req=%b addr=%h want 0/00", bus.imem_req, bus.imem_addr);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b instr=%h pc4=%h want 0/0/0", bus.out_valid, bus.out_instr, bus.out_pc_plus4);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (fetch_count !== 32'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf: fetch=%0d flush=%0d want 0/0", fetch_count, flush_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h want 1/00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL stream_c0: req=%b addr=%h want 1/00", bus.imem_req, bus.imem_addr);
        end
        tick(1'b1, 1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_c1: valid=%b want 0", bus.out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, '0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== word_at(exp_pc) || bus.out_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b instr=%h pc4=%h want 1/%h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc_plus4, word_at(exp_pc), exp_pc + 32'd4);
            end
            exp_pc += 32'd4;
        end
`ifdef FETCH_PERF_EN
        tick(1'b0, 1'b0, '0);
        checks++;
        if (fetch_count !== 32'd20) begin
            errors++;
            $display("FAIL stream_perf: fetch=%0d want 20", fetch_count);
        end
`endif
    endtask

    task automatic test_stall();
        int reqs;
        do_reset(1'b1);
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, '0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== word_at(exp_pc)) begin
                errors++;
                $display("FAIL stall_pre_%0d: valid=%b instr=%h want 1/%h", i, bus.out_valid, bus.out_instr, word_at(exp_pc));
            end
            exp_pc += 32'd4;
        end
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, '0);
            if (bus.imem_req === 1'b1) reqs++;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== word_at(exp_pc) || bus.out_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b instr=%h pc4=%h want 1/%h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc_plus4, word_at(exp_pc), exp_pc + 32'd4);
            end
        end
        checks++;
        if (reqs > 2) begin
            errors++;
            $display("FAIL stall_reqs: issued=%0d want <=2", reqs);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, '0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== word_at(exp_pc) || bus.out_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL stall_post_%0d: valid=%b instr=%h pc4=%h want 1/%h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc_plus4, word_at(exp_pc), exp_pc + 32'd4);
            end
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        for (int c = 1; c <= 20; c++) begin
            tick(1'b1, c == 10, 32'h0000_0042);
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_instr !== word_at(exp_pc) || bus.out_pc_plus4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL redir_c%0d: instr=%h pc4=%h want %h/%h", c, bus.out_instr, bus.out_pc_plus4, word_at(exp_pc), exp_pc + 32'd4);
                end
                exp_pc += 32'd4;
            end
            if (c == 10) begin
                exp_pc = 32'h40;
                checks++;
                if (bus.imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_req_r: req=%b want 0", bus.imem_req);
                end
            end
            if (c == 11) begin
                checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h10) begin
                    errors++;
                    $display("FAIL redir_req_r1: req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr);
                end
            end
            if (c == 11 || c == 12) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_bubble_c%0d: valid=%b want 0", c, bus.out_valid);
                end
            end
            if (c == 13) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1000_0010 || bus.out_pc_plus4 !== 32'h44) begin
                    errors++;
                    $display("FAIL redir_target: valid=%b instr=%h pc4=%h want 1/10000010/44", bus.out_valid, bus.out_instr, bus.out_pc_plus4);
                end
            end
        end
    endtask

    task automatic test_flush_full();
        do_reset(1'b0);
        repeat (4) tick(1'b0, 1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1000_0000) begin
            errors++;
            $display("FAIL full_pre: valid=%b instr=%h want 1/10000000", bus.out_valid, bus.out_instr);
        end
        tick(1'b1, 1'b1, 32'h80);
        for (int c = 1; c <= 3; c++) begin
            tick(1'b1, 1'b0, '0);
            checks++;
            if (bus.out_valid !== (c == 3)) begin
                errors++;
                $display("FAIL full_valid_r%0d: valid=%b want %b", c, bus.out_valid, c == 3);
            end
`ifdef FETCH_PERF_EN
            if (c == 1) begin
                checks++;
                if (fetch_count !== 32'd0 || flush_count !== 16'd1) begin
                    errors++;
                    $display("FAIL full_perf: fetch=%0d flush=%0d want 0/1", fetch_count, flush_count);
                end
            end
`endif
        end
        checks++;
        if (bus.out_instr !== 32'h1000_0020 || bus.out_pc_plus4 !== 32'h84) begin
            errors++;
            $display("FAIL full_target: instr=%h pc4=%h want 10000020/84", bus.out_instr, bus.out_pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        repeat (4) tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 32'h100);
        tick(1'b1, 1'b1, 32'h200);
        exp_pc = 32'h200;
        for (int c = 1; c <= 8; c++) begin
            tick(1'b1, 1'b0, '0);
            if (c < 3) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_bubble_%0d: valid=%b want 0", c, bus.out_valid);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_instr !== word_at(exp_pc) || bus.out_pc_plus4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL b2b_%0d: valid=%b instr=%h pc4=%h want 1/%h/%h", c, bus.out_valid, bus.out_instr, bus.out_pc_plus4, word_at(exp_pc), exp_pc + 32'd4);
                end
                exp_pc += 32'd4;
            end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (flush_count !== 16'd2) begin
            errors++;
            $display("FAIL b2b_perf: flush=%0d want 2", flush_count);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick(1'b1, 1'b0, '0);
            if (c < 3) begin
                a = 32'hFFFF_FFF8 + 32'(4 * c);
                checks++;
                if (bus_w.imem_req !== 1'b1 || bus_w.imem_addr !== a[9:2]) begin
                    errors++;
                    $display("FAIL wrap_addr_%0d: req=%b addr=%h want 1/%h", c, bus_w.imem_req, bus_w.imem_addr, a[9:2]);
                end
            end
            if (c >= 2) begin
                a = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
                checks++;
                if (bus_w.out_valid !== 1'b1 || bus_w.out_instr !== word_at(a) || bus_w.out_pc_plus4 !== a + 32'd4) begin
                    errors++;
                    $display("FAIL wrap_out_%0d: valid=%b instr=%h pc4=%h want 1/%h/%h", c, bus_w.out_valid, bus_w.out_instr, bus_w.out_pc_plus4, word_at(a), a + 32'd4);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        tick(1'b0, 1'b1, 32'h200);
        repeat (5) tick(1'b0, 1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1000_0080) begin
            errors++;
            $display("FAIL mid_pre: valid=%b instr=%h want 1/10000080", bus.out_valid, bus.out_instr);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_pc_plus4 !== 32'h0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: valid=%b instr=%h pc4=%h req=%b addr=%h want 0/0/0/0/00", bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.imem_req, bus.imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tick(1'b1, 1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_c1: valid=%b want 0", bus.out_valid);
        end
        tick(1'b1, 1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1000_0000 || bus.out_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL mid_first: valid=%b instr=%h pc4=%h want 1/10000000/4", bus.out_valid, bus.out_instr, bus.out_pc_plus4);
        end
    endtask

    // model: exp_pc is the next address on the architectural path; reqs/popsf bound outstanding work
    task automatic test_random();
        int reqs;
        int popsf;
        int pops;
        int flushes;
        logic rdy;
        logic rd;
        logic [31:0] rpc;
        do_reset(1'b1);
        reqs = (bus.imem_req === 1'b1) ? 1 : 0;
        popsf = 0;
        pops = 0;
        flushes = 0;
        for (int i = 0; i < 600; i++) begin
            rdy = $urandom_range(0, 3) != 0;
            rd = $urandom_range(0, 24) == 0;
            rpc = $urandom;
            tick(rdy, rd, rpc);
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_instr !== word_at(exp_pc) || bus.out_pc_plus4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL rand_%0d: instr=%h pc4=%h want %h/%h", i, bus.out_instr, bus.out_pc_plus4, word_at(exp_pc), exp_pc + 32'd4);
                end
                if (rdy && !rd) begin
                    exp_pc += 32'd4;
                    popsf++;
                    pops++;
                end
            end
            if (rd) begin
                checks++;
                if (bus.imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_redir_req_%0d: req=%b want 0", i, bus.imem_req);
                end
                exp_pc = rpc & 32'hFFFF_FFFC;
                reqs = 0;
                popsf = 0;
                flushes++;
            end else begin
                if (bus.imem_req === 1'b1) reqs++;
                checks++;
                if (reqs - popsf > 2) begin
                    errors++;
                    $display("FAIL rand_credit_%0d: outstanding=%0d want <=2", i, reqs - popsf);
                end
            end
        end
        checks++;
        if (pops < 150) begin
            errors++;
            $display("FAIL rand_progress: pops=%0d want >=150", pops);
        end
`ifdef FETCH_PERF_EN
        tick(1'b0, 1'b0, '0);
        checks++;
        if (fetch_count !== 32'(pops) || flush_count !== 16'(flushes)) begin
            errors++;
            $display("FAIL rand_perf: fetch=%0d flush=%0d want %0d/%0d", fetch_count, flush_count, pops, flushes);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        bus.out_ready = 1'b0;
        bus_w.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_flush_full();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
